// File: rtl/tron_trail_scanout.sv
// tron_trail_scanout: raster-locked scan of the trail BRAM into pixel colours,
// with border/head overlay and flashing of a losing player.
module tron_trail_scanout #(
  parameter int COLOR_W = 10,
  parameter int FLASH_FRAMES = 15,
  parameter logic [3*COLOR_W-1:0] P1_COLOR = 30'h3FF00000,
  parameter logic [3*COLOR_W-1:0] P2_COLOR = 30'h000FFC00,
  parameter logic [3*COLOR_W-1:0] HEAD_COLOR = 30'h3FFFFFFF,
  parameter logic [3*COLOR_W-1:0] WALL_COLOR = 30'h1FF7FDFF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pix_valid,
  input  logic [9:0]           pix_x,
  input  logic [9:0]           pix_y,
  input  logic                 frame_start,
  input  logic [7:0]           p1_x,
  input  logic [6:0]           p1_y,
  input  logic [7:0]           p2_x,
  input  logic [6:0]           p2_y,
  input  logic                 p1_lost,
  input  logic                 p2_lost,
  output logic [14:0]          rd_addr,
  input  logic [1:0]           rd_data,
  output logic [3*COLOR_W-1:0] rgb,
  output logic                 rgb_valid
);
  localparam int CW = FLASH_FRAMES > 1 ? $clog2(FLASH_FRAMES) : 1;
  typedef enum logic {SHOW, BLANK} phase_t;
  phase_t phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] cx, h1x_q, h1x_d, h2x_q, h2x_d;
  logic [6:0] cy, h1y_q, h1y_d, h2y_q, h2y_d;
  logic in_d, any_lost, wrap;
  logic [5:0] m1_q, m1_d, m2_q, m2_d;
  logic [1:0] d2_q, d2_d;
  logic [14:0] rd_addr_q, rd_addr_d;
  logic [3*COLOR_W-1:0] rgb_q, rgb_d;
  logic rgb_valid_q, rgb_valid_d;
  logic v2, bd2, hh1, hh2, bl1, bl2;
  // Border, head hits and blanking are resolved at sample time so a frame_start
  // only affects pixels sampled after it.
  assign {v2, bd2, hh1, hh2, bl1, bl2} = m2_q;
  always_comb begin
    in_d = pix_valid && pix_x < 10'd640 && pix_y < 10'd480;
    cx = pix_x[9:2];
    cy = pix_y[8:2];
    rd_addr_d = in_d ? {1'b0, cy, 7'd0} + {3'd0, cy, 5'd0} + {7'd0, cx} : rd_addr_q;
    m1_d = {in_d, cx == 8'd0 || cx == 8'd159 || cy == 7'd0 || cy == 7'd119,
            cx == h1x_q && cy == h1y_q, cx == h2x_q && cy == h2y_q,
            p1_lost && phase_q == BLANK, p2_lost && phase_q == BLANK};
    m2_d = m1_q;
    d2_d = rd_data;
    rgb_valid_d = v2;
    rgb_d = !v2 ? '0 : bd2 ? WALL_COLOR :
            hh1 ? (bl1 ? '0 : HEAD_COLOR) : hh2 ? (bl2 ? '0 : HEAD_COLOR) :
            d2_q == 2'b01 ? (bl1 ? '0 : P1_COLOR) : d2_q == 2'b10 ? (bl2 ? '0 : P2_COLOR) :
            d2_q == 2'b11 ? WALL_COLOR : '0;
    h1x_d = frame_start ? p1_x : h1x_q;
    h1y_d = frame_start ? p1_y : h1y_q;
    h2x_d = frame_start ? p2_x : h2x_q;
    h2y_d = frame_start ? p2_y : h2y_q;
    any_lost = p1_lost || p2_lost;
    wrap = cnt_q == CW'(FLASH_FRAMES - 1);
    cnt_d = !any_lost ? '0 : !frame_start ? cnt_q : wrap ? '0 : cnt_q + 1'b1;
    phase_d = !any_lost ? SHOW : (frame_start && wrap) ? (phase_q == SHOW ? BLANK : SHOW) : phase_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_addr_q <= '0;
      m1_q <= '0;
      m2_q <= '0;
      d2_q <= '0;
      rgb_q <= '0;
      rgb_valid_q <= 1'b0;
      h1x_q <= '0;
      h1y_q <= '0;
      h2x_q <= '0;
      h2y_q <= '0;
      cnt_q <= '0;
      phase_q <= SHOW;
    end else begin
      rd_addr_q <= rd_addr_d;
      m1_q <= m1_d;
      m2_q <= m2_d;
      d2_q <= d2_d;
      rgb_q <= rgb_d;
      rgb_valid_q <= rgb_valid_d;
      h1x_q <= h1x_d;
      h1y_q <= h1y_d;
      h2x_q <= h2x_d;
      h2y_q <= h2y_d;
      cnt_q <= cnt_d;
      phase_q <= phase_d;
    end
  end
  assign rd_addr = rd_addr_q;
  assign rgb = rgb_q;
  assign rgb_valid = rgb_valid_q;
endmodule

// File: tb/tb_tron_trail_scanout.sv
// tb_tron_trail_scanout: directed and randomized checks of the trail scanout
// against a rule-level colour model and a behavioural BRAM.
module tb_tron_trail_scanout;
  localparam int FF = 15;
  localparam logic [29:0] P1C = 30'h3FF00000;
  localparam logic [29:0] P2C = 30'h000FFC00;
  localparam logic [29:0] HDC = 30'h3FFFFFFF;
  localparam logic [29:0] WLC = 30'h1FF7FDFF;
  logic clk = 1'b0;
  logic reset = 1'b0, pix_valid = 1'b0, frame_start = 1'b0;
  logic [9:0] pix_x = '0, pix_y = '0;
  logic [7:0] p1_x = '0, p2_x = '0;
  logic [6:0] p1_y = '0, p2_y = '0;
  logic p1_lost = 1'b0, p2_lost = 1'b0;
  logic [14:0] rd_addr;
  logic [1:0] rd_data;
  logic [29:0] rgb;
  logic rgb_valid;
  logic [1:0] mem [0:19199];
  int total = 0, bad = 0;
  logic [29:0] e_rgb [3];
  logic e_v [3];
  logic [14:0] e_addr;
  int n, m1x, m1y, m2x, m2y;

  tron_trail_scanout dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .frame_start(frame_start), .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
    .p1_lost(p1_lost), .p2_lost(p2_lost), .rd_addr(rd_addr), .rd_data(rd_data),
    .rgb(rgb), .rgb_valid(rgb_valid)
  );

  always #10 clk = ~clk;
  assign rd_data = mem[rd_addr];

  function automatic logic in_a();
    return pix_valid && pix_x < 640 && pix_y < 480;
  endfunction

  function automatic logic [29:0] ref_col();
    int cx = int'(pix_x) / 4;
    int cy = int'(pix_y) / 4;
    logic ph = ((n / FF) % 2) == 1;
    logic b1 = p1_lost && ph;
    logic b2 = p2_lost && ph;
    logic [1:0] d;
    if (!in_a()) return '0;
    if (cx == 0 || cx == 159 || cy == 0 || cy == 119) return WLC;
    if (cx == m1x && cy == m1y) return b1 ? '0 : HDC;
    if (cx == m2x && cy == m2y) return b2 ? '0 : HDC;
    d = mem[cy * 160 + cx];
    if (d == 2'b01) return b1 ? '0 : P1C;
    if (d == 2'b10) return b2 ? '0 : P2C;
    if (d == 2'b11) return WLC;
    return '0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      e_rgb[0] <= '0; e_rgb[1] <= '0; e_rgb[2] <= '0;
      e_v[0] <= 1'b0; e_v[1] <= 1'b0; e_v[2] <= 1'b0;
      e_addr <= '0; n <= 0;
      m1x <= 0; m1y <= 0; m2x <= 0; m2y <= 0;
    end else begin
      e_rgb[0] <= ref_col(); e_rgb[1] <= e_rgb[0]; e_rgb[2] <= e_rgb[1];
      e_v[0] <= in_a(); e_v[1] <= e_v[0]; e_v[2] <= e_v[1];
      if (in_a()) e_addr <= 15'(int'(pix_y) / 4 * 160 + int'(pix_x) / 4);
      if (frame_start) begin
        m1x <= int'(p1_x); m1y <= int'(p1_y); m2x <= int'(p2_x); m2y <= int'(p2_y);
      end
      if (!(p1_lost || p2_lost)) n <= 0;
      else if (frame_start) n <= n + 1;
    end
  end

  task automatic step(input int x, input int y, input logic v, input logic fs);
    pix_x = 10'(x); pix_y = 10'(y); pix_valid = v; frame_start = fs;
    @(negedge clk);
  endtask

  task automatic flush();
    repeat (3) step(0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    repeat (5) step($urandom_range(0, 639), $urandom_range(0, 479), 1'b1, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step($urandom_range(0, 639), $urandom_range(0, 479), 1'b1, 1'b0);
      total++;
      if (rgb !== '0 || rgb_valid !== 1'b0 || rd_addr !== '0) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d rgb=%h valid=%b addr=%0d want 0/0/0", i, rgb, rgb_valid, rd_addr);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(40 + 4 * i, 40, 1'b1, 1'b0);
      total++;
      if (rgb_valid !== (i == 2)) begin
        bad++;
        $display("FAIL reset_release edge=%0d valid=%b want %b", i + 1, rgb_valid, i == 2);
      end
    end
    total++;
    if (rgb !== e_rgb[2]) begin
      bad++;
      $display("FAIL reset_first_pix rgb=%h want %h", rgb, e_rgb[2]);
    end
  endtask

  task automatic test_address();
    step(8, 4, 1'b1, 1'b0);
    total++;
    if (rd_addr !== 15'd162) begin bad++; $display("FAIL addr_8_4 got=%0d want 162", rd_addr); end
    step(639, 479, 1'b1, 1'b0);
    total++;
    if (rd_addr !== 15'd19199) begin bad++; $display("FAIL addr_max got=%0d want 19199", rd_addr); end
    step(700, 10, 1'b1, 1'b0);
    step(100, 100, 1'b0, 1'b0);
    total++;
    if (rd_addr !== 15'd19199) begin bad++; $display("FAIL addr_hold got=%0d want 19199", rd_addr); end
  endtask

  task automatic test_colour();
    logic [29:0] want [3];
    want[0] = P1C; want[1] = P2C; want[2] = '0;
    for (int k = 0; k < 3; k++) begin
      flush();
      mem[10 * 160 + 10] = (k == 0) ? 2'b01 : (k == 1) ? 2'b10 : 2'b00;
      step(40, 40, 1'b1, 1'b0);
      step(0, 0, 1'b0, 1'b0);
      step(0, 0, 1'b0, 1'b0);
      total++;
      if (rgb !== want[k] || rgb_valid !== 1'b1) begin
        bad++;
        $display("FAIL colour code=%0d rgb=%h valid=%b want %h/1", k, rgb, rgb_valid, want[k]);
      end
    end
  endtask

  task automatic test_blank();
    flush();
    mem[10 * 160 + 10] = 2'b01;
    mem[25 * 160] = 2'b00;
    step(40, 40, 1'b0, 1'b0);
    step(700, 40, 1'b1, 1'b0);
    step(0, 100, 1'b1, 1'b0);
    total++;
    if (rgb !== '0 || rgb_valid !== 1'b0) begin bad++; $display("FAIL blank_invalid rgb=%h valid=%b want 0/0", rgb, rgb_valid); end
    step(0, 0, 1'b0, 1'b0);
    total++;
    if (rgb !== '0 || rgb_valid !== 1'b0) begin bad++; $display("FAIL blank_x700 rgb=%h valid=%b want 0/0", rgb, rgb_valid); end
    step(0, 0, 1'b0, 1'b0);
    total++;
    if (rgb !== WLC || rgb_valid !== 1'b1) begin bad++; $display("FAIL border rgb=%h valid=%b want %h/1", rgb, rgb_valid, WLC); end
  endtask

  task automatic test_heads();
    flush();
    mem[10 * 160 + 12] = 2'b01;
    mem[10 * 160 + 13] = 2'b01;
    p1_x = 8'd12; p1_y = 7'd10;
    step(48, 40, 1'b1, 1'b0);
    step(0, 0, 1'b0, 1'b0);
    step(0, 0, 1'b0, 1'b0);
    total++;
    if (rgb !== P1C) begin bad++; $display("FAIL head_midframe rgb=%h want %h", rgb, P1C); end
    step(0, 0, 1'b0, 1'b1);
    step(48, 40, 1'b1, 1'b0);
    step(0, 0, 1'b0, 1'b0);
    step(0, 0, 1'b0, 1'b0);
    total++;
    if (rgb !== HDC) begin bad++; $display("FAIL head_latched rgb=%h want %h", rgb, HDC); end
    p1_x = 8'd13;
    step(52, 40, 1'b1, 1'b1);
    step(52, 40, 1'b1, 1'b0);
    step(0, 0, 1'b0, 1'b0);
    total++;
    if (rgb !== P1C) begin bad++; $display("FAIL head_same_cycle rgb=%h want %h", rgb, P1C); end
    step(0, 0, 1'b0, 1'b0);
    total++;
    if (rgb !== HDC) begin bad++; $display("FAIL head_next_cycle rgb=%h want %h", rgb, HDC); end
  endtask

  task automatic test_flash();
    logic [29:0] w;
    flush();
    mem[20 * 160 + 20] = 2'b10;
    mem[20 * 160 + 21] = 2'b01;
    p2_lost = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      step(0, 0, 1'b0, 1'b1);
      step(80, 80, 1'b1, 1'b0);
      step(84, 80, 1'b1, 1'b0);
      step(0, 0, 1'b0, 1'b0);
      w = (k >= 15 && k <= 29) ? 30'h0 : P2C;
      total++;
      if (rgb !== w) begin bad++; $display("FAIL flash_p2 pulse=%0d rgb=%h want %h", k, rgb, w); end
      step(0, 0, 1'b0, 1'b0);
      total++;
      if (rgb !== P1C) begin bad++; $display("FAIL flash_p1 pulse=%0d rgb=%h want %h", k, rgb, P1C); end
    end
    p2_lost = 1'b0;
    flush();
  endtask

  task automatic test_random();
    int x, y;
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 299) == 0) p1_lost = ~p1_lost;
      if ($urandom_range(0, 299) == 0) p2_lost = ~p2_lost;
      if ($urandom_range(0, 15) == 0) begin
        p1_x = 8'($urandom_range(1, 158)); p1_y = 7'($urandom_range(1, 118));
        p2_x = ($urandom_range(0, 3) == 0) ? p1_x : 8'($urandom_range(1, 158));
        p2_y = ($urandom_range(0, 3) == 0) ? p1_y : 7'($urandom_range(1, 118));
      end
      case ($urandom_range(0, 3))
        0: begin x = m1x * 4 + $urandom_range(0, 3); y = m1y * 4 + $urandom_range(0, 3); end
        1: begin x = m2x * 4 + $urandom_range(0, 3); y = m2y * 4 + $urandom_range(0, 3); end
        default: begin x = $urandom_range(0, 799); y = $urandom_range(0, 524); end
      endcase
      step(x, y, $urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0);
      total++;
      if (rgb !== e_rgb[2] || rgb_valid !== e_v[2]) begin
        bad++;
        $display("FAIL random i=%0d rgb=%h valid=%b want %h/%b", i, rgb, rgb_valid, e_rgb[2], e_v[2]);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 19200; i++) mem[i] = 2'($urandom);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_address();
    test_colour();
    test_blank();
    test_heads();
    test_flash();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
